da2_dual_serializer: RTL and testbench
======================================

Name: da2_dual_serializer

Overview:
- Downstream consumer of the tone/sample generator: takes two 12-bit samples and a sample-rate strobe, and emits the dual-channel serial frame for the PmodDA2 (two DAC121S101 converters sharing SCLK and nSYNC).
- Each START rising edge launches one 16-bit frame per channel (4 control bits + 12 data bits, MSB first), then pulses DONE.
- Sits between the 12-bit audio sample register and the JA header pins.

Parameters:
- CLK_DIV, 2, system-clock cycles per SCLK half-period; SCLK = CLK/(2*CLK_DIV); legal range 1..255.
- CTRL_BITS, 4'b0000, the four leading frame bits (2 don't-care + PD1:PD0); 00 = normal operation.

Ports:
- CLK  input  1  system clock (50 MHz domain)
- RST  input  1  asynchronous, active-high reset
- START  input  1  sample-rate strobe, level signal from another divider; rising edge requests a frame
- DATA1  input  12  channel-1 sample, unsigned
- DATA2  input  12  channel-2 sample, unsigned
- D1  output  1  serial data, channel 1 (PmodDA2 pin 2)
- D2  output  1  serial data, channel 2 (PmodDA2 pin 3)
- CLK_OUT  output  1  SCLK to both DACs (pin 4)
- nSYNC  output  1  active-low frame select (pin 1)
- BUSY  output  1  high from frame launch until return to IDLE
- DONE  output  1  one-CLK pulse when the 16th bit has been sampled
- OVERRUN  output  1  one-CLK pulse when a START edge arrives while BUSY

Behaviour:
- Reset (async assert, sync release): nSYNC=1, CLK_OUT=1, D1=D2=0, BUSY=0, DONE=0, OVERRUN=0, state=IDLE, synchronizer flops=0.
- START passes through a 2-flop synchronizer plus an edge-detect flop. An edge is recognised 3 CLK after the START rise.
- State IDLE: idle outputs as at reset. On a recognised edge:
  - latch {CTRL_BITS,DATA1} and {CTRL_BITS,DATA2} into 16-bit shift registers (DATA sampled on this cycle);
  - drive bit15 on D1/D2; nSYNC<=0; BUSY<=1;
  - bitcnt<=15, divcnt<=0; go to SHIFT.
- State SHIFT: divcnt counts 0..CLK_DIV-1; on wrap, CLK_OUT toggles.
  - CLK_OUT 1->0: DAC sampling edge; D1/D2 are not changed.
  - CLK_OUT 0->1 with bitcnt>0: shift left, drive next bit, bitcnt--.
  - CLK_OUT 0->1 with bitcnt==0: go to QUIET; nSYNC<=1; DONE=1 for that cycle.
  - D1/D2 therefore change only on SCLK rising edges, giving ≥CLK_DIV clocks of setup and hold around each falling edge.
- State QUIET: nSYNC=1, CLK_OUT=1, D1=D2=0 for 2*CLK_DIV clocks (minimum nSYNC-high time), then IDLE, BUSY<=0.
- nSYNC low duration: exactly 32*CLK_DIV clocks. Frame period floor (launch to next possible launch): 34*CLK_DIV+1 clocks.
- START edge recognised while BUSY (SHIFT or QUIET): the request is dropped and OVERRUN pulses 1 cycle. The in-flight frame is unaffected.
- An edge recognised in the same cycle the FSM enters IDLE is accepted.
- DATA1/DATA2 changes after latch have no effect on the current frame.
- RST mid-frame: immediate return to reset values. The partial frame is aborted; nSYNC high cancels the DAC write.
- Width rules: bitcnt 4 bits; divcnt 8 bits; no arithmetic on sample data.

Decomposition:
- Shared audio package holds:
  - DAC_WIDTH=12, FRAME_BITS=16;
  - state encoding IDLE/SHIFT/QUIET (2-bit localparams);
  - PD mode constants (PD_NORMAL=2'b00, PD_1K=2'b01, PD_100K=2'b10, PD_HIZ=2'b11).
- One natural sub-module: sync_edge_detect (2-flop synchronizer + rising-edge pulse, async-high reset), reusable for button and strobe inputs elsewhere.

Test Plan:
- CLK_DIV=1, DATA1=12'hA5C, DATA2=12'h3F0, one START rise:
  - bits captured on CLK_OUT falling edges are D1=16'h0A5C, D2=16'h03F0;
  - nSYNC low exactly 32 CLK; one DONE pulse; BUSY falls 2 CLK after nSYNC rises.
- CLK_DIV=3, DATA1=12'hFFF, DATA2=12'h000:
  - SCLK period 6 CLK; D1 stream 0000_1111_1111_1111, D2 all zeros;
  - no D1/D2 transition within 3 CLK of any CLK_OUT falling edge.
- START toggling at 20 kHz-equivalent (period 2500 CLK), DATA incrementing each frame: every frame carries the value present at its launch cycle; OVERRUN never asserts.
- Second START rise 10 CLK after the first (CLK_DIV=1): exactly one OVERRUN pulse, one frame emitted, DONE count=1.
- RST asserted at bit 8 of a frame:
  - same-cycle nSYNC=1, CLK_OUT=1, D1=D2=0, BUSY=0;
  - after release, the next START produces a complete, correct 16-bit frame.
- START held high continuously after one rise: exactly one frame; no retrigger until START falls and rises again.

Source files
------------

// File: rtl/da2_dual_serializer_pkg.sv
// Shared constants for the PmodDA2 audio path: sample/frame widths, serializer
// state encoding and DAC121S101 power-down mode codes.
package da2_dual_serializer_pkg;

    localparam int unsigned DAC_WIDTH  = 12;
    localparam int unsigned FRAME_BITS = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_QUIET = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        QUIET = ST_QUIET
    } state_e;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

endpackage

// File: rtl/da2_dual_serializer_sync_edge_detect.sv
// Two-flop synchronizer followed by an edge-detect flop; pulse_o is high for
// one clock once a rising edge of async_i has crossed into the clk_i domain.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic pulse_o
);

    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d  = {sync_q[1:0], async_i};
        pulse_o = sync_q[1] & ~sync_q[2];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

endmodule

// File: rtl/da2_dual_serializer.sv
// Dual-channel PmodDA2 serializer: each START rising edge sends one 16-bit frame
// per DAC (control bits + 12-bit sample, MSB first) on a shared SCLK/nSYNC.
module da2_dual_serializer
    import da2_dual_serializer_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter logic [3:0]  CTRL_BITS = {2'b00, PD_NORMAL}
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [DAC_WIDTH-1:0] DATA1,
    input  logic [DAC_WIDTH-1:0] DATA2,
    output logic                 D1,
    output logic                 D2,
    output logic                 CLK_OUT,
    output logic                 nSYNC,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 OVERRUN
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   sr1_q, sr1_d, sr2_q, sr2_d;
    logic [3:0]              bitcnt_q, bitcnt_d;
    logic [7:0]              divcnt_q, divcnt_d;
    logic                    clk_out_q, clk_out_d;
    logic                    nsync_q, nsync_d;
    logic                    d1_q, d1_d, d2_q, d2_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    overrun_q, overrun_d;
    logic                    start_pulse;
    logic                    div_wrap;

    sync_edge_detect u_start_sync (
        .clk_i   (CLK),
        .rst_i   (RST),
        .async_i (START),
        .pulse_o (start_pulse)
    );

    assign div_wrap = (divcnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        sr1_d     = sr1_q;
        sr2_d     = sr2_q;
        bitcnt_d  = bitcnt_q;
        divcnt_d  = divcnt_q;
        clk_out_d = clk_out_q;
        nsync_d   = nsync_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    sr1_d     = {CTRL_BITS, DATA1};
                    sr2_d     = {CTRL_BITS, DATA2};
                    d1_d      = CTRL_BITS[3];
                    d2_d      = CTRL_BITS[3];
                    nsync_d   = 1'b0;
                    busy_d    = 1'b1;
                    bitcnt_d  = BIT_LAST;
                    divcnt_d  = 8'd0;
                    clk_out_d = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                overrun_d = start_pulse;
                if (div_wrap) begin
                    divcnt_d  = 8'd0;
                    clk_out_d = ~clk_out_q;
                    // Data only moves on SCLK rising edges; falling edges are the DAC sample points.
                    if (!clk_out_q) begin
                        if (bitcnt_q != 4'd0) begin
                            sr1_d    = {sr1_q[FRAME_BITS-2:0], sr1_q[FRAME_BITS-1]};
                            sr2_d    = {sr2_q[FRAME_BITS-2:0], sr2_q[FRAME_BITS-1]};
                            d1_d     = sr1_q[FRAME_BITS-2];
                            d2_d     = sr2_q[FRAME_BITS-2];
                            bitcnt_d = bitcnt_q - 4'd1;
                        end else begin
                            nsync_d  = 1'b1;
                            d1_d     = 1'b0;
                            d2_d     = 1'b0;
                            done_d   = 1'b1;
                            bitcnt_d = 4'd1;
                            state_d  = QUIET;
                        end
                    end
                end else begin
                    divcnt_d = divcnt_q + 8'd1;
                end
            end
            QUIET: begin
                overrun_d = start_pulse;
                // bitcnt reused to count two divider periods of nSYNC-high time.
                if (div_wrap) begin
                    divcnt_d = 8'd0;
                    if (bitcnt_q == 4'd0) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q - 4'd1;
                    end
                end else begin
                    divcnt_d = divcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            sr1_q     <= '0;
            sr2_q     <= '0;
            bitcnt_q  <= 4'd0;
            divcnt_q  <= 8'd0;
            clk_out_q <= 1'b1;
            nsync_q   <= 1'b1;
            d1_q      <= 1'b0;
            d2_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr1_q     <= sr1_d;
            sr2_q     <= sr2_d;
            bitcnt_q  <= bitcnt_d;
            divcnt_q  <= divcnt_d;
            clk_out_q <= clk_out_d;
            nsync_q   <= nsync_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign D1      = d1_q;
    assign D2      = d2_q;
    assign CLK_OUT = clk_out_q;
    assign nSYNC   = nsync_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_da2_dual_serializer.sv
// Bench for da2_dual_serializer: two instances (CLK_DIV=1 and 3) share stimulus;
// a bus monitor decodes frames, a request-level model predicts frames/overruns.
module tb_da2_dual_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] data1 = '0;
    logic [11:0] data2 = '0;

    logic d1_a, d2_a, sclk_a, ns_a, busy_a, done_a, ovr_a;
    logic d1_b, d2_b, sclk_b, ns_b, busy_b, done_b, ovr_b;

    int checks = 0;
    int errors = 0;
    longint cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    da2_dual_serializer #(.CLK_DIV(1)) u_dut_div1 (
        .CLK(clk), .RST(rst), .START(start), .DATA1(data1), .DATA2(data2),
        .D1(d1_a), .D2(d2_a), .CLK_OUT(sclk_a), .nSYNC(ns_a),
        .BUSY(busy_a), .DONE(done_a), .OVERRUN(ovr_a)
    );

    da2_dual_serializer #(.CLK_DIV(3)) u_dut_div3 (
        .CLK(clk), .RST(rst), .START(start), .DATA1(data1), .DATA2(data2),
        .D1(d1_b), .D2(d2_b), .CLK_OUT(sclk_b), .nSYNC(ns_b),
        .BUSY(busy_b), .DONE(done_b), .OVERRUN(ovr_b)
    );

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // ---------------- bus monitor ----------------
    typedef struct {
        logic [15:0] f1;
        logic [15:0] f2;
        int          low;
        int          bits;
    } rx_t;

    rx_t rx0[$];
    rx_t rx1[$];
    rx_t mon_r;

    logic        cs[2], ns[2], dd1[2], dd2[2], bs[2], dn[2], ov[2];
    logic        p_cs[2], p_ns[2], p_d1[2], p_d2[2];
    logic [15:0] cap1[2], cap2[2];
    int run[2], low[2], bits[2], gap_cnt[2], busy_gap[2];
    bit gap_act[2];
    int done_cnt[2], ovr_cnt[2], viol[2], half_bad[2], rx_total[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            p_cs[k] = 1'b1; p_ns[k] = 1'b1; p_d1[k] = 1'b0; p_d2[k] = 1'b0;
            run[k] = 0; low[k] = 0; bits[k] = 0; gap_cnt[k] = 0; busy_gap[k] = -1;
            gap_act[k] = 0; done_cnt[k] = 0; ovr_cnt[k] = 0; viol[k] = 0;
            half_bad[k] = 0; rx_total[k] = 0; cap1[k] = '0; cap2[k] = '0;
        end
    end

    always @(negedge clk) begin
        cs[0] = sclk_a; ns[0] = ns_a; dd1[0] = d1_a; dd2[0] = d2_a;
        bs[0] = busy_a; dn[0] = done_a; ov[0] = ovr_a;
        cs[1] = sclk_b; ns[1] = ns_b; dd1[1] = d1_b; dd2[1] = d2_b;
        bs[1] = busy_b; dn[1] = done_b; ov[1] = ovr_b;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                run[k] = 0; low[k] = 0; bits[k] = 0; gap_act[k] = 0;
            end else begin
                if (dn[k]) done_cnt[k]++;
                if (ov[k]) ovr_cnt[k]++;
                if (!ns[k]) low[k]++;
                if (!p_ns[k]) begin
                    run[k]++;
                    if (cs[k] != p_cs[k]) begin
                        if (run[k] != div_of(k)) half_bad[k]++;
                        run[k] = 0;
                    end
                    if (!ns[k] && (dd1[k] != p_d1[k] || dd2[k] != p_d2[k])
                        && !(cs[k] && !p_cs[k])) viol[k]++;
                end
                if (!cs[k] && p_cs[k] && !ns[k]) begin
                    cap1[k] = {cap1[k][14:0], dd1[k]};
                    cap2[k] = {cap2[k][14:0], dd2[k]};
                    bits[k]++;
                end
                if (ns[k] && !p_ns[k]) begin
                    mon_r.f1 = cap1[k]; mon_r.f2 = cap2[k];
                    mon_r.low = low[k]; mon_r.bits = bits[k];
                    if (k == 0) rx0.push_back(mon_r);
                    else rx1.push_back(mon_r);
                    rx_total[k]++;
                    low[k] = 0; bits[k] = 0; run[k] = 0;
                    gap_act[k] = 1; gap_cnt[k] = 0;
                end
                if (gap_act[k]) begin
                    if (!bs[k]) begin
                        busy_gap[k] = gap_cnt[k];
                        gap_act[k] = 0;
                    end else begin
                        gap_cnt[k]++;
                    end
                end
            end
            p_cs[k] = cs[k]; p_ns[k] = ns[k]; p_d1[k] = dd1[k]; p_d2[k] = dd2[k];
        end
    end

    // ---------------- reference model ----------------
    // A request launches 3 clocks after START rises unless the previous frame's
    // 34*DIV-clock occupancy has not yet elapsed, in which case it is an overrun.
    longint      last_l[2] = '{-100000, -100000};
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    int          exp_ovr[2] = '{0, 0};

    task automatic request(input logic [11:0] a, input logic [11:0] b);
        longint r = cyc + 3;
        for (int k = 0; k < 2; k++) begin
            if (r >= last_l[k] + 34 * div_of(k) + 1) begin
                last_l[k] = r;
                if (k == 0) exp0.push_back({4'h0, a, 4'h0, b});
                else exp1.push_back({4'h0, a, 4'h0, b});
            end else begin
                exp_ovr[k]++;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            if (cyc < last_l[k] + 32 * div_of(k)) begin
                if (k == 0) void'(exp0.pop_back());
                else void'(exp1.pop_back());
            end
            last_l[k] = -100000;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rise(input logic [11:0] a, input logic [11:0] b);
        data1 = a;
        data2 = b;
        start = 1'b1;
        request(a, b);
    endtask

    task automatic check_frames();
        rx_t r;
        logic [31:0] e;
        check("div1 frame count", 32'(rx0.size()), 32'(exp0.size()));
        check("div3 frame count", 32'(rx1.size()), 32'(exp1.size()));
        while (rx0.size() > 0 && exp0.size() > 0) begin
            r = rx0.pop_front(); e = exp0.pop_front();
            check("div1 frame data", {r.f1, r.f2}, e);
            check("div1 nsync low", 32'(r.low), 32'd32);
            check("div1 bit count", 32'(r.bits), 32'd16);
        end
        while (rx1.size() > 0 && exp1.size() > 0) begin
            r = rx1.pop_front(); e = exp1.pop_front();
            check("div3 frame data", {r.f1, r.f2}, e);
            check("div3 nsync low", 32'(r.low), 32'd96);
            check("div3 bit count", 32'(r.bits), 32'd16);
        end
        rx0.delete(); rx1.delete(); exp0.delete(); exp1.delete();
    endtask

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t tbl[5];
    rx_t  tr;

    initial begin
        tbl[0] = '{12'hA5C, 12'h3F0, 16'h0A5C, 16'h03F0};
        tbl[1] = '{12'hFFF, 12'h000, 16'h0FFF, 16'h0000};
        tbl[2] = '{12'h000, 12'hFFF, 16'h0000, 16'h0FFF};
        tbl[3] = '{12'h123, 12'hABC, 16'h0123, 16'h0ABC};
        tbl[4] = '{12'h801, 12'h7FE, 16'h0801, 16'h07FE};

        tick(4);
        check("div1 reset outputs", {25'd0, ns_a, sclk_a, d1_a, d2_a, busy_a, done_a, ovr_a},
              32'b1100000);
        check("div3 reset outputs", {25'd0, ns_b, sclk_b, d1_b, d2_b, busy_b, done_b, ovr_b},
              32'b1100000);
        rst = 1'b0;
        tick(5);
        check("idle after release", {30'd0, ns_a, ns_b}, 32'b11);

        // table-driven single frames
        for (int i = 0; i < 5; i++) begin
            rise(tbl[i].a, tbl[i].b);
            tick(5);
            start = 1'b0;
            tick(150);
            check("div1 table frames", 32'(rx0.size()), 32'd1);
            check("div3 table frames", 32'(rx1.size()), 32'd1);
            if (rx0.size() > 0) begin
                tr = rx0.pop_front();
                check("div1 table data", {tr.f1, tr.f2}, {tbl[i].e1, tbl[i].e2});
            end
            if (rx1.size() > 0) begin
                tr = rx1.pop_front();
                check("div3 table data", {tr.f1, tr.f2}, {tbl[i].e1, tbl[i].e2});
            end
            rx0.delete(); rx1.delete(); exp0.delete(); exp1.delete();
        end
        check("div1 busy fall after nsync", 32'(busy_gap[0]), 32'd2);
        check("div3 busy fall after nsync", 32'(busy_gap[1]), 32'd6);
        check("div1 done count", 32'(done_cnt[0]), 32'd5);

        // second START rise 10 clocks after the first
        rise(12'h111, 12'h222);
        tick(4);
        start = 1'b0;
        tick(6);
        rise(12'h333, 12'h444);
        tick(4);
        start = 1'b0;
        tick(150);
        check("overrun pulses div1", 32'(ovr_cnt[0]), 32'd1);
        check_frames();

        // 2500-clock strobe with incrementing data
        for (int i = 0; i < 4; i++) begin
            rise(12'(12'h100 + i), 12'(12'hE00 - i));
            tick(1250);
            start = 1'b0;
            tick(1250);
        end
        check_frames();

        // randomized request spacing and data
        for (int i = 0; i < 30; i++) begin
            rise(12'($urandom), 12'($urandom));
            tick($urandom_range(3, 20));
            start = 1'b0;
            tick($urandom_range(3, 150));
        end
        tick(150);
        check_frames();

        // reset mid-frame (bit 8 of the CLK_DIV=3 frame)
        rise(12'h5A5, 12'hC3C);
        tick(4);
        start = 1'b0;
        tick(47);
        check("div3 mid-frame before reset", {31'd0, ns_b}, 32'd0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("div1 outputs in reset", {27'd0, ns_a, sclk_a, d1_a, d2_a, busy_a}, 32'b11000);
        check("div3 outputs in reset", {27'd0, ns_b, sclk_b, d1_b, d2_b, busy_b}, 32'b11000);
        tick(3);
        rst = 1'b0;
        tick(5);
        check_frames();
        rise(12'h9C3, 12'h36A);
        tick(5);
        start = 1'b0;
        tick(150);
        check_frames();

        // START held high: one frame until it falls and rises again
        rise(12'h0F0, 12'hF0F);
        tick(400);
        start = 1'b0;
        tick(10);
        rise(12'h777, 12'h888);
        tick(5);
        start = 1'b0;
        tick(150);
        check_frames();

        for (int k = 0; k < 2; k++) begin
            check("done count vs frames", 32'(done_cnt[k]), 32'(rx_total[k]));
            check("overrun count", 32'(ovr_cnt[k]), 32'(exp_ovr[k]));
            check("data change near sample edge", 32'(viol[k]), 32'd0);
            check("sclk half period", 32'(half_bad[k]), 32'd0);
        end
        check("div1 idle at end", {31'd0, busy_a}, 32'd0);
        check("div3 idle at end", {31'd0, busy_b}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
